// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's instruction-memory, redirect, decode-handshake and fault signals.
// The master modport is the fetch stage's view of the bundle; the slave modport is the
// view of the surrounding logic (memory, branch unit and decoder).
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr, out_pc_plus4, fault, fault_pc,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr, out_pc_plus4, fault, fault_pc,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
// - Owns the program counter and drives the instruction-memory read address.
// - Buffers {pc, instruction} pairs in a small FIFO that feeds decode over a
//   valid/ready handshake.
// - An aligned redirect flushes the FIFO and reloads the PC.
// - A misaligned redirect latches a sticky fault and halts the stage until reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  fetch_stage_if.master  bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [31:0]   pc_r;
  logic          fault_r;
  logic [31:0]   fault_pc_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [31:0]   mem_pc_r    [FIFO_DEPTH];
  logic [31:0]   mem_instr_r [FIFO_DEPTH];

  logic          redirect_s;
  logic          misaligned_s;
  logic          push_s;
  logic          pop_s;
  logic          head_valid_s;
  logic [31:0]   head_pc_s;
  logic [31:0]   head_instr_s;

  // Decide this cycle's redirect/push/pop; a redirect outranks both FIFO operations.
  always_comb begin
    redirect_s   = 1'b0;
    misaligned_s = (bus.redirect_pc[1:0] != 2'b00);
    push_s       = 1'b0;
    pop_s        = 1'b0;
    if (state_r == RUN) begin
      redirect_s = bus.redirect_valid;
      push_s     = !bus.redirect_valid && (count_r < CNT_FULL);
    end else begin
      redirect_s = 1'b0;
      push_s     = 1'b0;
    end
    pop_s = !redirect_s && (count_r != CNT_ZERO) && bus.out_ready;
  end

  // Next-state logic: only a misaligned redirect leaves RUN, and nothing but reset leaves HALT.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (redirect_s && misaligned_s) begin
          state_next_s = HALT;
        end else begin
          state_next_s = RUN;
        end
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = HALT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Program counter: reload on an aligned redirect, advance by one word on every push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (redirect_s && !misaligned_s) begin
      pc_r <= bus.redirect_pc;
    end else if (push_s) begin
      pc_r <= pc_r + 32'd4;
    end
  end

  // Sticky fault capture for a misaligned redirect target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_r    <= 1'b0;
      fault_pc_r <= 32'h0000_0000;
    end else if (redirect_s && misaligned_s) begin
      fault_r    <= 1'b1;
      fault_pc_r <= bus.redirect_pc;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer outright.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r  <= CNT_ZERO;
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
    end else if (redirect_s) begin
      count_r  <= CNT_ZERO;
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage: capture the current PC and the word the memory returns for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc_r[i]    <= 32'h0000_0000;
        mem_instr_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      mem_pc_r[wr_ptr_r]    <= pc_r;
      mem_instr_r[wr_ptr_r] <= bus.imem_instr;
    end
  end

  // Head-of-FIFO view toward decode; data fields read as zero while the buffer is empty.
  always_comb begin
    head_valid_s = (count_r != CNT_ZERO);
    head_pc_s    = 32'h0000_0000;
    head_instr_s = 32'h0000_0000;
    if (head_valid_s) begin
      head_pc_s    = mem_pc_r[rd_ptr_r];
      head_instr_s = mem_instr_r[rd_ptr_r];
    end else begin
      head_pc_s    = 32'h0000_0000;
      head_instr_s = 32'h0000_0000;
    end
  end

  assign bus.imem_addr    = pc_r;
  assign bus.out_valid    = head_valid_s;
  assign bus.out_pc       = head_pc_s;
  assign bus.out_instr    = head_instr_s;
  assign bus.out_pc_plus4 = head_valid_s ? (head_pc_s + 32'd4) : 32'h0000_0000;
  assign bus.fault        = fault_r;
  assign bus.fault_pc     = fault_pc_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// - A queue-based model of the fetch buffer is checked against the DUT on every falling edge.
// - Each directed scenario also checks a few hand-computed literal values.
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic clk;
  logic reset;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory: a distinct word for every address.
  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    return addr ^ 32'hDEAD_0000;
  endfunction

  assign bus.imem_instr = imem_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_halt;
  logic        m_fault;
  logic [31:0] m_fault_pc;
  logic [31:0] m_acc[$];
  logic [31:0] dut_acc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc       = 32'h0000_0000;
    m_halt     = 1'b0;
    m_fault    = 1'b0;
    m_fault_pc = 32'h0000_0000;
  endtask

  task automatic model_update();
    int  sz;
    bit  pop;
    bit  push;
    if (!m_halt) begin
      if (bus.redirect_valid) begin
        m_q.delete();
        if ((bus.redirect_pc % 32'd4) != 32'd0) begin
          m_halt     = 1'b1;
          m_fault    = 1'b1;
          m_fault_pc = bus.redirect_pc;
        end else begin
          m_pc = bus.redirect_pc;
        end
      end else begin
        sz   = m_q.size();
        pop  = (sz > 0) && bus.out_ready;
        push = (sz < DEPTH);
        if (pop) m_acc.push_back(m_q.pop_front());
        if (push) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // One clock: log the DUT's accepted entry, advance the model, settle after the falling edge.
  task automatic step();
    @(posedge clk);
    if (bus.out_valid && bus.out_ready && !bus.redirect_valid)
      dut_acc.push_back(bus.out_pc);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    check_en = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0000_0000;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    m_acc.delete();
    dut_acc.delete();
    check_en = 1'b1;
  endtask

  task automatic check_stream(input string name, input logic [31:0] start, input int n);
    check({name, "_model_len"}, 32'(m_acc.size()), 32'(n));
    check({name, "_dut_len"}, 32'(dut_acc.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < m_acc.size())   check({name, "_model_pc"}, m_acc[i], start + 32'(4 * i));
      if (i < dut_acc.size()) check({name, "_dut_pc"}, dut_acc[i], start + 32'(4 * i));
    end
  endtask

  // Compare process: every falling edge out of reset, the DUT must match the model.
  always @(negedge clk) begin
    logic [31:0] e_pc;
    if (check_en && !reset) begin
      e_pc = (m_q.size() > 0) ? m_q[0] : 32'h0000_0000;
      check("imem_addr", bus.imem_addr, m_pc);
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, (m_q.size() > 0)});
      check("out_pc", bus.out_pc, e_pc);
      check("out_instr", bus.out_instr, (m_q.size() > 0) ? imem_word(e_pc) : 32'h0000_0000);
      check("out_pc_plus4", bus.out_pc_plus4, (m_q.size() > 0) ? e_pc + 32'd4 : 32'h0000_0000);
      check("fault", {31'd0, bus.fault}, {31'd0, m_fault});
      check("fault_pc", bus.fault_pc, m_fault_pc);
    end
  end

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0000_0000;
    #1;
    check("reset_imem_addr", bus.imem_addr, 32'h0000_0000);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_out_pc", bus.out_pc, 32'h0000_0000);
    check("reset_fault", {31'd0, bus.fault}, 32'd0);

    // 1: streaming with ready held high
    do_reset();
    bus.out_ready = 1'b1;
    step();
    check("t1_first_pc", bus.out_pc, 32'h0000_0000);
    check("t1_first_instr", bus.out_instr, 32'hDEAD_0000);
    check("t1_first_plus4", bus.out_pc_plus4, 32'h0000_0004);
    repeat (8) step();
    check_stream("t1_stream", 32'h0000_0000, 8);

    // 2: back-pressure fills the buffer, then drains without loss
    do_reset();
    bus.out_ready = 1'b0;
    repeat (5) step();
    check("t2_imem_addr", bus.imem_addr, 32'h0000_0008);
    check("t2_head_pc", bus.out_pc, 32'h0000_0000);
    check("t2_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (4) step();
    check_stream("t2_stream", 32'h0000_0000, 4);

    // 3: redirect flushes the buffered 0x0/0x4
    do_reset();
    bus.out_ready = 1'b0;
    repeat (2) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0010;
    step();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("t3_first_pc", bus.out_pc, 32'h0000_0010);
    repeat (2) step();
    check_stream("t3_stream", 32'h0000_0010, 2);

    // 4: redirect overrides a same-cycle pop
    do_reset();
    bus.out_ready = 1'b1;
    repeat (3) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    step();
    bus.redirect_valid = 1'b0;
    step();
    check("t4_next_pc", bus.out_pc, 32'h0000_0040);
    check_stream("t4_stream", 32'h0000_0000, 2);

    // 5: misaligned redirect halts and faults until reset
    do_reset();
    bus.out_ready = 1'b1;
    repeat (2) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0002;
    step();
    bus.redirect_valid = 1'b0;
    check("t5_fault", {31'd0, bus.fault}, 32'd1);
    check("t5_fault_pc", bus.fault_pc, 32'h0000_0002);
    check("t5_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (3) step();
    check("t5_addr_frozen", bus.imem_addr, 32'h0000_0008);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0020;
    step();
    bus.redirect_valid = 1'b0;
    step();
    check("t5_ignored_addr", bus.imem_addr, 32'h0000_0008);
    check("t5_ignored_valid", {31'd0, bus.out_valid}, 32'd0);
    do_reset();
    step();
    check("t5_restart_pc", bus.out_pc, 32'h0000_0000);
    check("t5_fault_clear", {31'd0, bus.fault}, 32'd0);

    // 6: asynchronous reset mid-cycle, then PC wrap
    do_reset();
    bus.out_ready = 1'b1;
    repeat (3) step();
    #1;
    check_en = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_async_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t6_async_addr", bus.imem_addr, 32'h0000_0000);
    do_reset();
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    step();
    check("t6_wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
    check("t6_wrap_instr", bus.out_instr, 32'h2152_FFFC);
    check("t6_wrap_plus4", bus.out_pc_plus4, 32'h0000_0000);
    check("t6_wrap_addr", bus.imem_addr, 32'h0000_0000);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
